uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver: variable data width, optional parity, 1 or 2 stop bits.

---
 rtl/uart_rx_cfg.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (5..9 data bits, optional even/odd
// parity, 1 or 2 stop bits) with parity/framing error reporting and false
// start-bit rejection. Runs on sysclk with a synchronous active-high reset.
//
// Optional build macro UART_RX_MAJORITY_EN: when defined, every bit value is
// the 2-of-3 majority of three consecutive line samples around the bit
// centre; when undefined a single centre sample is used and the extra sample
// flops do not exist.
//
// Output protocol: o_rx_d is a one-cycle valid strobe with no ready/back
// pressure; o_rx_byte, o_parity_err and o_frame_err are valid in the strobe
// cycle and hold until the next strobe (or reset).
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sysclk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_rx_serial,
    output logic                 o_rx_d,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic                 bit_val;
    logic                 armed;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_pend, par_pend_n;
    logic                 frm_pend, frm_pend_n;

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    // Two older line samples so the decision cycle sees centre-1, centre, centre+1.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign bit_val = rx_s;
`endif

    // A break leaves the line low after DONE; require the line to be seen
    // high again before another start edge is accepted.
    always_ff @(posedge sysclk) begin
        if (i_rst) armed <= 1'b1;
        else       armed <= rx_s | (armed & (state != DONE));
    end

    // State and datapath registers; result registers load on entry to DONE.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_pend     <= 1'b0;
            frm_pend     <= 1'b0;
            o_rx_byte    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            shreg    <= shreg_n;
            par_pend <= par_pend_n;
            frm_pend <= frm_pend_n;
            if (state_n == DONE) begin
                o_rx_byte    <= shreg_n;
                o_parity_err <= par_pend_n;
                o_frame_err  <= frm_pend_n;
            end
        end
    end

    // Next-state and datapath logic; all decisions happen at bit centres.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        par_pend_n = par_pend;
        frm_pend_n = frm_pend;

        case (state)
            IDLE: begin
                if (i_rx && !rx_s && armed) begin
                    state_n    = START;
                    clk_cnt_n  = '0;
                    par_pend_n = 1'b0;
                    frm_pend_n = 1'b0;
                end
            end
            START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = bit_val ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    shreg_n   = {bit_val, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n  = '0;
                    par_pend_n = (((^shreg) ^ bit_val) != ODD_PAR);
                    state_n    = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    if (!bit_val) frm_pend_n = 1'b1;
                    if (stop_idx == STOP_LAST) state_n = DONE;
                    else                       stop_idx_n = 1'b1;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Disabling the receiver abandons any frame in progress.
        if (state != IDLE && !i_rx) state_n = IDLE;
    end

    assign o_rx_d = (state == DONE);
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg. Four receivers with
// different configurations share clock, reset and enable; each has its own
// serial pin. Expected frames are queued as {dut, parity_err, frame_err, byte}.
module tb_uart_rx_cfg;

    localparam int CPB     = 16;
    localparam int LAT_DEF = (1 + 8 + 0 + 1) * CPB - CPB / 2 + 3;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] SPIKE_EXP = 8'h00;
`else
    localparam logic [7:0] SPIKE_EXP = 8'h04;
`endif

    logic       sysclk = 1'b0;
    logic       i_rst  = 1'b1;
    logic       i_rx   = 1'b1;
    logic       pin    [4];
    logic       rx_d   [4];
    logic       perr   [4];
    logic       ferr   [4];
    logic       busy   [4];
    logic [7:0] byte0, byte1, byte2;
    logic [8:0] byte3;

    logic [12:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int pulse_cnt [4] = '{default: 0};
    int pulse_cyc [4] = '{default: 0};

    // Clock and cycle counter
    always #4 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_def (
        .sysclk(sysclk), .i_rst(i_rst), .i_rx(i_rx), .i_rx_serial(pin[0]),
        .o_rx_d(rx_d[0]), .o_rx_byte(byte0), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_busy(busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1)) dut_par (
        .sysclk(sysclk), .i_rst(i_rst), .i_rx(i_rx), .i_rx_serial(pin[1]),
        .o_rx_d(rx_d[1]), .o_rx_byte(byte1), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_busy(busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_s2 (
        .sysclk(sysclk), .i_rst(i_rst), .i_rx(i_rx), .i_rx_serial(pin[2]),
        .o_rx_d(rx_d[2]), .o_rx_byte(byte2), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_busy(busy[2]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(2)) dut_d9 (
        .sysclk(sysclk), .i_rst(i_rst), .i_rx(i_rx), .i_rx_serial(pin[3]),
        .o_rx_d(rx_d[3]), .o_rx_byte(byte3), .o_parity_err(perr[3]),
        .o_frame_err(ferr[3]), .o_busy(busy[3]));

    function automatic logic [8:0] get_byte(input int s);
        case (s)
            0:       return {1'b0, byte0};
            1:       return {1'b0, byte1};
            2:       return {1'b0, byte2};
            default: return byte3;
        endcase
    endfunction

    // Scoreboard: every o_rx_d pulse pops and compares one expected frame
    always @(negedge sysclk) begin
        logic [12:0] act;
        logic [12:0] exp;
        for (int s = 0; s < 4; s++) begin
            if (rx_d[s] === 1'b1) begin
                pulse_cnt[s] = pulse_cnt[s] + 1;
                pulse_cyc[s] = cyc;
                act = {2'(s), perr[s], ferr[s], get_byte(s)};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: dut=%0d perr=%b ferr=%b byte=%h pulsed, expected no pulse",
                             s, perr[s], ferr[s], get_byte(s));
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL sb_frame: got dut=%0d perr=%b ferr=%b byte=%h, expected dut=%0d perr=%b ferr=%b byte=%h",
                                 act[12:11], act[10], act[9], act[8:0], exp[12:11], exp[10], exp[9], exp[8:0]);
                    end
                end
            end
        end
    end

    // Driver: bits[0] is the start bit; spike_bit inverts one cycle at that bit's centre
    task automatic send_frame(input int s, input logic [12:0] bits, input int nbits, input int spike_bit);
        for (int n = 0; n < nbits; n++) begin
            @(posedge sysclk); #1;
            pin[s] = bits[n];
            if (n == 0) fall_cyc = cyc;
            if (n == spike_bit) begin
                repeat (8) @(posedge sysclk);
                #1 pin[s] = ~bits[n];
                @(posedge sysclk);
                #1 pin[s] = bits[n];
                repeat (6) @(posedge sysclk);
            end else begin
                repeat (CPB - 1) @(posedge sysclk);
            end
        end
        @(posedge sysclk); #1 pin[s] = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(posedge sysclk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d frames outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge sysclk);
        #1 i_rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({rx_d[s], perr[s], ferr[s], busy[s], get_byte(s)} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs: dut=%0d rx_d=%b perr=%b ferr=%b busy=%b byte=%h, expected all 0",
                         s, rx_d[s], perr[s], ferr[s], busy[s], get_byte(s));
            end
        end
    endtask

    task automatic test_defaults();
        int p0;
        p0 = pulse_cnt[0];
        exp_q.push_back({2'd0, 1'b0, 1'b0, 9'h0CB});
        send_frame(0, 13'({1'b1, 8'hCB, 1'b0}), 10, -1);
        wait_drain("defaults");
        repeat (20) @(posedge sysclk);
        #1;
        checks++;
        if (pulse_cnt[0] - p0 !== 1) begin
            errors++;
            $display("FAIL defaults_pulses: got %0d pulses, expected 1", pulse_cnt[0] - p0);
        end
        checks++;
        if (pulse_cyc[0] - fall_cyc !== LAT_DEF) begin
            errors++;
            $display("FAIL defaults_latency: got %0d cycles, expected %0d", pulse_cyc[0] - fall_cyc, LAT_DEF);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt[0];
        exp_q.push_back({2'd0, 1'b0, 1'b0, 9'h012});
        exp_q.push_back({2'd0, 1'b0, 1'b0, 9'h034});
        send_frame(0, 13'({1'b1, 8'h12, 1'b0}), 10, -1);
        send_frame(0, 13'({1'b1, 8'h34, 1'b0}), 10, -1);
        wait_drain("back_to_back");
        checks++;
        if (pulse_cnt[0] - p0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses, expected 2", pulse_cnt[0] - p0);
        end
    endtask

    task automatic test_parity();
        exp_q.push_back({2'd1, 1'b1, 1'b0, 9'h0CB});
        send_frame(1, 13'({1'b1, 1'b0, 8'hCB, 1'b0}), 11, -1);
        wait_drain("parity_bad");
        checks++;
        if (perr[1] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad_held: got perr=%b, expected 1", perr[1]);
        end
        exp_q.push_back({2'd1, 1'b0, 1'b0, 9'h0CB});
        send_frame(1, 13'({1'b1, 1'b1, 8'hCB, 1'b0}), 11, -1);
        wait_drain("parity_good");
        checks++;
        if (perr[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_good_held: got perr=%b, expected 0", perr[1]);
        end
    endtask

    task automatic test_stop2();
        exp_q.push_back({2'd2, 1'b0, 1'b1, 9'h05A});
        send_frame(2, 13'({1'b0, 1'b1, 8'h5A, 1'b0}), 11, -1);
        wait_drain("stop2_bad");
        checks++;
        if (ferr[2] !== 1'b1) begin
            errors++;
            $display("FAIL stop2_bad_held: got ferr=%b, expected 1", ferr[2]);
        end
        repeat (10) @(posedge sysclk);
        exp_q.push_back({2'd2, 1'b0, 1'b0, 9'h03C});
        send_frame(2, 13'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, -1);
        wait_drain("stop2_good");
        checks++;
        if (ferr[2] !== 1'b0 || byte2 !== 8'h3C) begin
            errors++;
            $display("FAIL stop2_good_held: got ferr=%b byte=%h, expected ferr=0 byte=3c", ferr[2], byte2);
        end
    endtask

    task automatic test_data9();
        // 0x1A5 has five 1s, so odd parity is satisfied by a 0 parity bit
        exp_q.push_back({2'd3, 1'b0, 1'b0, 9'h1A5});
        send_frame(3, 13'({1'b1, 1'b0, 9'h1A5, 1'b0}), 12, -1);
        wait_drain("data9_good");
        checks++;
        if (byte3 !== 9'h1A5) begin
            errors++;
            $display("FAIL data9_byte: got %h, expected 1a5", byte3);
        end
        exp_q.push_back({2'd3, 1'b1, 1'b0, 9'h1A5});
        send_frame(3, 13'({1'b1, 1'b1, 9'h1A5, 1'b0}), 12, -1);
        wait_drain("data9_bad");
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulse_cnt[0];
        @(posedge sysclk); #1 pin[0] = 1'b0;
        repeat (4) @(posedge sysclk);
        #1 pin[0] = 1'b1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start_seen: got busy=%b, expected 1", busy[0]);
        end
        repeat (30) @(posedge sysclk);
        #1;
        checks++;
        if (busy[0] !== 1'b0 || pulse_cnt[0] !== p0) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b pulses=%0d, expected busy=0 pulses=0", busy[0], pulse_cnt[0] - p0);
        end
        exp_q.push_back({2'd0, 1'b0, 1'b0, 9'h0A5});
        send_frame(0, 13'({1'b1, 8'hA5, 1'b0}), 10, -1);
        wait_drain("glitch_recover");
    endtask

    task automatic test_break();
        int p0;
        p0 = pulse_cnt[0];
        exp_q.push_back({2'd0, 1'b0, 1'b1, 9'h000});
        @(posedge sysclk); #1 pin[0] = 1'b0;
        repeat (10 * CPB + 60) @(posedge sysclk);
        #1;
        checks++;
        if (busy[0] !== 1'b0 || pulse_cnt[0] - p0 !== 1) begin
            errors++;
            $display("FAIL break_no_retrigger: got busy=%b pulses=%0d, expected busy=0 pulses=1", busy[0], pulse_cnt[0] - p0);
        end
        pin[0] = 1'b1;
        repeat (20) @(posedge sysclk);
        wait_drain("break");
        exp_q.push_back({2'd0, 1'b0, 1'b0, 9'h096});
        send_frame(0, 13'({1'b1, 8'h96, 1'b0}), 10, -1);
        wait_drain("break_recover");
    endtask

    task automatic test_abort();
        int p0;
        p0 = pulse_cnt[0];
        fork
            send_frame(0, 13'({1'b1, 8'hFF, 1'b0}), 10, -1);
            begin
                repeat (71) @(posedge sysclk);
                #1;
                checks++;
                if (busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_busy_before: got %b, expected 1", busy[0]);
                end
                i_rx = 1'b0;
                @(posedge sysclk); #1;
                checks++;
                if (busy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_busy_after: got %b, expected 0", busy[0]);
                end
            end
        join
        i_rx = 1'b1;
        repeat (10) @(posedge sysclk);
        #1;
        checks++;
        if (pulse_cnt[0] !== p0 || byte0 !== 8'h96) begin
            errors++;
            $display("FAIL abort_hold: got pulses=%0d byte=%h, expected pulses=0 byte=96", pulse_cnt[0] - p0, byte0);
        end
    endtask

    task automatic test_rst_mid();
        int p0;
        p0 = pulse_cnt[0];
        fork
            send_frame(0, 13'({1'b1, 8'hFF, 1'b0}), 10, -1);
            begin
                repeat (71) @(posedge sysclk);
                #1;
                checks++;
                if (busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_busy_before: got %b, expected 1", busy[0]);
                end
                i_rst = 1'b1;
                @(posedge sysclk); #1 i_rst = 1'b0;
                checks++;
                if (byte0 !== 8'h00 || busy[0] !== 1'b0 || perr[0] !== 1'b0 || ferr[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid_clear: got byte=%h busy=%b perr=%b ferr=%b, expected all 0",
                             byte0, busy[0], perr[0], ferr[0]);
                end
            end
        join
        repeat (10) @(posedge sysclk);
        #1;
        checks++;
        if (pulse_cnt[0] !== p0) begin
            errors++;
            $display("FAIL rst_mid_pulses: got %0d pulses, expected 0", pulse_cnt[0] - p0);
        end
    endtask

    task automatic test_majority();
        exp_q.push_back({2'd0, 1'b0, 1'b0, 1'b0, SPIKE_EXP});
        send_frame(0, 13'({1'b1, 8'h00, 1'b0}), 10, 3);
        wait_drain("majority");
        checks++;
        if (byte0 !== SPIKE_EXP) begin
            errors++;
            $display("FAIL majority_byte: got %h, expected %h", byte0, SPIKE_EXP);
        end
    endtask

    // Watchdog: the sequence is a few thousand cycles long
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 4; s++) pin[s] = 1'b1;
        test_reset();
        test_defaults();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_data9();
        test_glitch();
        test_break();
        test_abort();
        test_rst_mid();
        test_majority();
        repeat (20) @(posedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
